// File: rtl/udp_decoder.sv
// UDP receive-side decoder: parses the 8-byte header from a 32-bit word stream,
// forwards payload words with byte-valid flags and verifies the one's-complement checksum.
module udp_decoder #(
  parameter logic [15:0] MIN_LEN = 16'd8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        data_av,
  input  logic [31:0] data_in,
  output logic [15:0] src_port,
  output logic [15:0] dest_port,
  output logic [15:0] len_out,
  output logic [31:0] data_out,
  output logic [3:0]  data_keep,
  output logic        wr_en,
  output logic        fin,
  output logic        chksum_ok,
  output logic        len_err,
  output logic        busy
);

  localparam logic [15:0] HDR_BYTES = 16'd8;

  typedef enum logic [2:0] {IDLE, HDR_2, DATA, CHECK, FIN} state_e;

  state_e      state_q, state_d;
  logic [15:0] src_q, src_d;
  logic [15:0] dst_q, dst_d;
  logic [15:0] len_out_q, len_out_d;
  logic [31:0] data_out_q, data_out_d;
  logic [3:0]  keep_q, keep_d;
  logic        wr_en_q, wr_en_d;
  logic        ok_q, ok_d;
  logic        lerr_q, lerr_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] rxchk_q, rxchk_d;
  logic [15:0] left_q, left_d;

  // 16-bit one's-complement add; the folded carry cannot overflow again
  function automatic logic [15:0] add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'b0, s[16]};
  endfunction

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    len_out_d  = len_out_q;
    data_out_d = data_out_q;
    keep_d     = keep_q;
    wr_en_d    = 1'b0;
    ok_d       = ok_q;
    lerr_d     = lerr_q;
    acc_d      = acc_q;
    rxchk_d    = rxchk_q;
    left_d     = left_q;
    case (state_q)
      IDLE: begin
        if (start && data_av) begin
          src_d   = data_in[31:16];
          dst_d   = data_in[15:0];
          acc_d   = add16(data_in[31:16], data_in[15:0]);
          ok_d    = 1'b0;
          lerr_d  = 1'b0;
          state_d = HDR_2;
        end
      end
      HDR_2: begin
        if (data_av) begin
          rxchk_d = data_in[15:0];
          acc_d   = add16(add16(acc_q, data_in[31:16]), data_in[15:0]);
          if (data_in[31:16] < MIN_LEN) begin
            lerr_d    = 1'b1;
            len_out_d = '0;
            state_d   = FIN;
          end else if (data_in[31:16] <= HDR_BYTES) begin
            len_out_d = '0;
            state_d   = CHECK;
          end else begin
            len_out_d = data_in[31:16] - HDR_BYTES;
            left_d    = data_in[31:16] - HDR_BYTES;
            state_d   = DATA;
          end
        end
      end
      DATA: begin
        if (data_av) begin
          acc_d      = add16(add16(acc_q, data_in[31:16]), data_in[15:0]);
          data_out_d = data_in;
          wr_en_d    = 1'b1;
          case (left_q)
            16'd1:   keep_d = 4'b1000;
            16'd2:   keep_d = 4'b1100;
            16'd3:   keep_d = 4'b1110;
            default: keep_d = 4'b1111;
          endcase
          if (left_q > 16'd4) begin
            left_d = left_q - 16'd4;
          end else begin
            left_d  = '0;
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        ok_d    = (rxchk_q == 16'h0000) || (acc_q == 16'hFFFF);
        state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      len_out_q  <= '0;
      data_out_q <= '0;
      keep_q     <= '0;
      wr_en_q    <= 1'b0;
      ok_q       <= 1'b0;
      lerr_q     <= 1'b0;
      acc_q      <= '0;
      rxchk_q    <= '0;
      left_q     <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      len_out_q  <= len_out_d;
      data_out_q <= data_out_d;
      keep_q     <= keep_d;
      wr_en_q    <= wr_en_d;
      ok_q       <= ok_d;
      lerr_q     <= lerr_d;
      acc_q      <= acc_d;
      rxchk_q    <= rxchk_d;
      left_q     <= left_d;
    end
  end

  assign src_port  = src_q;
  assign dest_port = dst_q;
  assign len_out   = len_out_q;
  assign data_out  = data_out_q;
  assign data_keep = keep_q;
  assign wr_en     = wr_en_q;
  assign chksum_ok = ok_q;
  assign len_err   = lerr_q;
  assign fin       = (state_q == FIN);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_udp_decoder.sv
// Directed self-checking bench for udp_decoder: header parsing, payload forwarding,
// checksum verdict, length errors, input gaps and asynchronous reset.
module tb_udp_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        data_av = 1'b0;
  logic [31:0] data_in = '0;
  logic [15:0] src_port, dest_port, len_out;
  logic [31:0] data_out;
  logic [3:0]  data_keep;
  logic        wr_en, fin, chksum_ok, len_err, busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] wr_data [64];
  logic [3:0]  wr_keep [64];
  int          wr_cnt = 0;
  int          fin_cnt = 0;

  udp_decoder #(.MIN_LEN(16'd8)) dut (
    .clk(clk), .reset(rst_n), .start(start), .data_av(data_av), .data_in(data_in),
    .src_port(src_port), .dest_port(dest_port), .len_out(len_out),
    .data_out(data_out), .data_keep(data_keep), .wr_en(wr_en), .fin(fin),
    .chksum_ok(chksum_ok), .len_err(len_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Event recorder: samples 2 time units after each rising edge
  always @(posedge clk) begin
    #2;
    if (wr_en && wr_cnt < 64) begin
      wr_data[wr_cnt] = data_out;
      wr_keep[wr_cnt] = data_keep;
      wr_cnt++;
    end
    if (fin) fin_cnt++;
  end

  task automatic send(input logic st, input logic [31:0] w);
    @(negedge clk);
    start = st; data_av = 1'b1; data_in = w;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      start = 1'b0; data_av = 1'b0; data_in = '0;
    end
  endtask

  task automatic wait_fin(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      start = 1'b0; data_av = 1'b0; data_in = '0;
      if (fin) begin cyc = i; break; end
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if ({src_port, dest_port, len_out, data_out, data_keep, wr_en, fin, chksum_ok, len_err, busy} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got src=%h dst=%h len=%h do=%h keep=%b wr=%b fin=%b ok=%b le=%b busy=%b want all 0",
        src_port, dest_port, len_out, data_out, data_keep, wr_en, fin, chksum_ok, len_err, busy);
    end
    idle(2);
    rst_n = 1'b1;
    idle(2);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic(input int gap);
    int c, bw, bf;
    bw = wr_cnt; bf = fin_cnt;
    send(1'b1, 32'h12345678);
    idle(gap);
    send(1'b0, 32'h000CF9A9);
    idle(gap);
    send(1'b0, 32'hDEADBEEF);
    wait_fin(c);
    n_cmp++; if (c !== 2) begin n_bad++; $display("FAIL basic_fin_latency gap=%0d: got %0d want 2", gap, c); end
    n_cmp++; if (src_port !== 16'h1234) begin n_bad++; $display("FAIL basic_src: got %h want 1234", src_port); end
    n_cmp++; if (dest_port !== 16'h5678) begin n_bad++; $display("FAIL basic_dst: got %h want 5678", dest_port); end
    n_cmp++; if (len_out !== 16'd4) begin n_bad++; $display("FAIL basic_len: got %0d want 4", len_out); end
    n_cmp++; if ({chksum_ok, len_err, busy} !== 3'b101) begin n_bad++; $display("FAIL basic_status: got ok/le/busy=%b want 101", {chksum_ok, len_err, busy}); end
    n_cmp++; if (wr_cnt - bw !== 1) begin n_bad++; $display("FAIL basic_wr_count gap=%0d: got %0d want 1", gap, wr_cnt - bw); end
    n_cmp++; if (wr_data[bw] !== 32'hDEADBEEF || wr_keep[bw] !== 4'b1111) begin
      n_bad++; $display("FAIL basic_payload: got %h/%b want deadbeef/1111", wr_data[bw], wr_keep[bw]); end
    idle(1);
    n_cmp++; if ({busy, fin} !== 2'b00 || fin_cnt - bf !== 1) begin
      n_bad++; $display("FAIL basic_end: got busy=%b fin=%b fins=%0d want 0 0 1", busy, fin, fin_cnt - bf); end
  endtask

  task automatic test_header_only(input logic [31:0] w2, input logic exp_ok);
    int c, bw;
    bw = wr_cnt;
    send(1'b1, 32'h12345678);
    send(1'b0, w2);
    wait_fin(c);
    n_cmp++; if (c !== 2) begin n_bad++; $display("FAIL hdr_fin_latency: got %0d want 2", c); end
    n_cmp++; if (len_out !== 16'd0) begin n_bad++; $display("FAIL hdr_len: got %0d want 0", len_out); end
    n_cmp++; if (chksum_ok !== exp_ok || len_err !== 1'b0) begin
      n_bad++; $display("FAIL hdr_chk w2=%h: got ok=%b le=%b want ok=%b le=0", w2, chksum_ok, len_err, exp_ok); end
    n_cmp++; if (wr_cnt !== bw) begin n_bad++; $display("FAIL hdr_no_wr: got %0d writes want 0", wr_cnt - bw); end
    idle(1);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL hdr_busy: got %b want 0", busy); end
  endtask

  task automatic test_partial();
    int c, bw;
    bw = wr_cnt;
    send(1'b1, 32'hABCD0042);
    send(1'b0, 32'h000D0000);
    send(1'b0, 32'h01020304);
    send(1'b0, 32'h05000000);
    wait_fin(c);
    n_cmp++; if (c !== 2) begin n_bad++; $display("FAIL part_fin_latency: got %0d want 2", c); end
    n_cmp++; if (len_out !== 16'd5) begin n_bad++; $display("FAIL part_len: got %0d want 5", len_out); end
    n_cmp++; if ({src_port, dest_port} !== 32'hABCD0042) begin n_bad++; $display("FAIL part_ports: got %h want abcd0042", {src_port, dest_port}); end
    n_cmp++; if (chksum_ok !== 1'b1) begin n_bad++; $display("FAIL part_chk_unused: got %b want 1", chksum_ok); end
    n_cmp++; if (wr_cnt - bw !== 2) begin n_bad++; $display("FAIL part_wr_count: got %0d want 2", wr_cnt - bw); end
    n_cmp++; if (wr_data[bw] !== 32'h01020304 || wr_keep[bw] !== 4'b1111) begin
      n_bad++; $display("FAIL part_word0: got %h/%b want 01020304/1111", wr_data[bw], wr_keep[bw]); end
    n_cmp++; if (wr_data[bw+1] !== 32'h05000000 || wr_keep[bw+1] !== 4'b1000) begin
      n_bad++; $display("FAIL part_word1: got %h/%b want 05000000/1000", wr_data[bw+1], wr_keep[bw+1]); end
    idle(1);
  endtask

  task automatic test_len_err();
    int c, bw;
    bw = wr_cnt;
    send(1'b1, 32'h11112222);
    send(1'b0, 32'h00040000);
    wait_fin(c);
    n_cmp++; if (c !== 1) begin n_bad++; $display("FAIL lerr_fin_latency: got %0d want 1", c); end
    n_cmp++; if ({len_err, chksum_ok} !== 2'b10) begin n_bad++; $display("FAIL lerr_flags: got le/ok=%b want 10", {len_err, chksum_ok}); end
    n_cmp++; if (len_out !== 16'd0) begin n_bad++; $display("FAIL lerr_len: got %0d want 0", len_out); end
    n_cmp++; if (wr_cnt !== bw) begin n_bad++; $display("FAIL lerr_no_wr: got %0d writes want 0", wr_cnt - bw); end
    idle(1);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL lerr_busy: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_data();
    int bf;
    bf = fin_cnt;
    send(1'b1, 32'h0A0B0C0D);
    send(1'b0, 32'h00100000);
    send(1'b0, 32'hAAAABBBB);
    idle(1);
    n_cmp++; if (wr_en !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL rst_pre: got wr=%b busy=%b want 1 1", wr_en, busy); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({src_port, dest_port, len_out, data_out, data_keep, wr_en, fin, chksum_ok, len_err, busy} !== '0) begin
      n_bad++; $display("FAIL rst_async_outputs: got src=%h dst=%h len=%h do=%h keep=%b wr=%b fin=%b ok=%b le=%b busy=%b want all 0",
        src_port, dest_port, len_out, data_out, data_keep, wr_en, fin, chksum_ok, len_err, busy);
    end
    idle(3);
    rst_n = 1'b1;
    idle(4);
    n_cmp++; if (fin_cnt !== bf) begin n_bad++; $display("FAIL rst_no_fin: got %0d fins want 0", fin_cnt - bf); end
    test_basic(0);
  endtask

  initial begin
    test_reset();
    test_basic(0);
    test_header_only(32'h0008974B, 1'b1);
    test_header_only(32'h00089740, 1'b0);
    test_partial();
    test_basic(3);
    test_len_err();
    test_reset_mid_data();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
